// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage with IF/ID register and one-entry capture buffer.
// Optional misaligned-target trap enabled by defining RV32_FETCH_MISALIGNED_EN.
module rv32_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000,
   parameter logic [31:0] NOP_INSN     = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_pc_in,
   output logic        instr_read_out,
   output logic [31:0] instr_address_out,
   input  logic [31:0] instr_read_value_in,
   input  logic        instr_ready_in,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out
`ifdef RV32_FETCH_MISALIGNED_EN
   ,
   output logic        misaligned_out
`endif
);

`ifdef RV32_FETCH_MISALIGNED_EN
   typedef enum logic [1:0] {FETCH, DRAIN, HOLD, TRAP} state_t;
`else
   typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
`endif

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pending;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;
   logic        handshake;
   logic        redirect;
   logic [31:0] target;

   assign instr_read_out    = !reset && (state == FETCH || state == DRAIN);
   assign instr_address_out = pc;
   assign handshake         = instr_read_out && instr_ready_in;

   // A redirect lands whenever no memory request is left outstanding.
   always_comb begin
      redirect = 1'b0;
      target   = branch_pc_in;
      case (state)
         FETCH:   redirect = branch_taken_in && handshake;
         DRAIN: begin
            redirect = handshake;
            if (!branch_taken_in) target = pending;
         end
         default: redirect = branch_taken_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_VECTOR;
         pending   <= '0;
         buf_pc    <= '0;
         buf_instr <= NOP_INSN;
         valid_out <= 1'b0;
         pc_out    <= '0;
         instr_out <= NOP_INSN;
`ifdef RV32_FETCH_MISALIGNED_EN
         misaligned_out <= 1'b0;
`endif
      end else begin
`ifdef RV32_FETCH_MISALIGNED_EN
         misaligned_out <= (state == TRAP) && stall_in && misaligned_out;
`endif
         case (state)
            FETCH: begin
               if (branch_taken_in) begin
                  valid_out <= 1'b0;
                  pc_out    <= '0;
                  instr_out <= NOP_INSN;
                  if (!handshake) begin
                     pending <= branch_pc_in;
                     state   <= DRAIN;
                  end
               end else if (handshake) begin
                  pc <= pc + 32'd4;
                  if (stall_in) begin
                     buf_pc    <= pc;
                     buf_instr <= instr_read_value_in;
                     state     <= HOLD;
                  end else begin
                     valid_out <= 1'b1;
                     pc_out    <= pc;
                     instr_out <= instr_read_value_in;
                  end
               end else if (!stall_in) begin
                  valid_out <= 1'b0;
                  pc_out    <= '0;
                  instr_out <= NOP_INSN;
               end
            end
            DRAIN: begin
               valid_out <= 1'b0;
               pc_out    <= '0;
               instr_out <= NOP_INSN;
               if (branch_taken_in) pending <= branch_pc_in;
            end
            HOLD: begin
               if (!branch_taken_in && !stall_in) begin
                  valid_out <= 1'b1;
                  pc_out    <= buf_pc;
                  instr_out <= buf_instr;
                  state     <= FETCH;
               end
            end
`ifdef RV32_FETCH_MISALIGNED_EN
            TRAP: begin
               if (!branch_taken_in && !stall_in) begin
                  valid_out <= 1'b0;
                  pc_out    <= '0;
                  instr_out <= NOP_INSN;
               end
            end
`endif
            default: state <= FETCH;
         endcase

         // Redirect overrides the per-state updates and always flushes IF/ID.
         if (redirect) begin
            valid_out <= 1'b0;
            pc_out    <= '0;
            instr_out <= NOP_INSN;
`ifdef RV32_FETCH_MISALIGNED_EN
            if (target[1]) begin
               valid_out      <= 1'b1;
               pc_out         <= target;
               misaligned_out <= 1'b1;
               state          <= TRAP;
            end else
`endif
            begin
               pc    <= target;
               state <= FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: directed scenarios followed by a random run
// scored against an instruction-stream model (memory returns address ^ 0xA5).
module tb_rv32_fetch;

   localparam logic [31:0] RV  = 32'h00000100;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_in;
   logic        branch_taken_in;
   logic [31:0] branch_pc_in;
   logic        instr_read_out;
   logic [31:0] instr_address_out;
   logic [31:0] instr_read_value_in;
   logic        instr_ready_in;
   logic        valid_out;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
`ifdef RV32_FETCH_MISALIGNED_EN
   logic        misaligned_out;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic        r_br, r_st, r_rdy, prev_pending;
   logic [31:0] r_bpc, exp_pc, prev_addr;
   int          consumed;

   always #5 clk = ~clk;

   assign instr_read_value_in = instr_address_out ^ 32'h000000A5;

   rv32_fetch #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
      .clk                 (clk),
      .reset               (reset),
      .stall_in            (stall_in),
      .branch_taken_in     (branch_taken_in),
      .branch_pc_in        (branch_pc_in),
      .instr_read_out      (instr_read_out),
      .instr_address_out   (instr_address_out),
      .instr_read_value_in (instr_read_value_in),
      .instr_ready_in      (instr_ready_in),
      .valid_out           (valid_out),
      .pc_out              (pc_out),
      .instr_out           (instr_out)
`ifdef RV32_FETCH_MISALIGNED_EN
      ,
      .misaligned_out      (misaligned_out)
`endif
   );

   task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic br, input logic [31:0] bpc,
                                input logic st, input logic rdy);
      reset           = rst;
      branch_taken_in = br;
      branch_pc_in    = bpc;
      stall_in        = st;
      instr_ready_in  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic v, input logic [31:0] p,
                              input logic [31:0] i, input logic rd, input logic [31:0] a);
      compare({tag, ".valid"}, 32'(valid_out), 32'(v));
      compare({tag, ".pc"}, pc_out, p);
      compare({tag, ".instr"}, instr_out, i);
      compare({tag, ".read"}, 32'(instr_read_out), 32'(rd));
      if (rd) compare({tag, ".addr"}, instr_address_out, a);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset and zero-wait streaming.
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("reset", 0, 32'h0, NOP, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("first", 1, 32'h100, 32'h1A5, 1, 32'h104);

      // Stall three cycles: 0x104 captured in the buffer, no further reads.
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stall1", 1, 32'h100, 32'h1A5, 0, 32'h0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stall2", 1, 32'h100, 32'h1A5, 0, 32'h0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stall3", 1, 32'h100, 32'h1A5, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("release", 1, 32'h104, 32'h1A1, 1, 32'h108);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("after_release", 1, 32'h108, 32'h1AD, 1, 32'h10C);

      // Wait states with a branch in the second wait cycle.
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wait1", 0, 32'h0, NOP, 1, 32'h10C);
      applyStimulus(0, 1, 32'h2000, 0, 0);
      checkOutput("wait2_branch", 0, 32'h0, NOP, 1, 32'h10C);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain3", 0, 32'h0, NOP, 1, 32'h10C);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain4", 0, 32'h0, NOP, 1, 32'h10C);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drain_done", 0, 32'h0, NOP, 1, 32'h2000);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("target", 1, 32'h2000, 32'h20A5, 1, 32'h2004);

      // Branch plus stall while HOLD: buffer dropped.
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("hold_enter", 1, 32'h2000, 32'h20A5, 0, 32'h0);
      applyStimulus(0, 1, 32'h40, 1, 1);
      checkOutput("hold_branch", 0, 32'h0, NOP, 1, 32'h40);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("hold_target", 1, 32'h40, 32'hE5, 1, 32'h44);

      // PC wrap-around.
      applyStimulus(0, 1, 32'hFFFFFFFC, 0, 1);
      checkOutput("wrap_branch", 0, 32'h0, NOP, 1, 32'hFFFFFFFC);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wrap", 1, 32'hFFFFFFFC, 32'hFFFFFF59, 1, 32'h0);

      // Reset while draining.
      applyStimulus(0, 1, 32'h500, 0, 0);
      checkOutput("drain_enter", 0, 32'h0, NOP, 1, 32'h0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("drain_reset", 0, 32'h0, NOP, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("post_reset", 1, 32'h100, 32'h1A5, 1, 32'h104);

`ifdef RV32_FETCH_MISALIGNED_EN
      applyStimulus(0, 1, 32'h302, 0, 1);
      checkOutput("trap", 1, 32'h302, NOP, 0, 32'h0);
      compare("trap.mis", 32'(misaligned_out), 32'd1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("trap_stall", 1, 32'h302, NOP, 0, 32'h0);
      compare("trap_stall.mis", 32'(misaligned_out), 32'd1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("trap_consumed", 0, 32'h0, NOP, 0, 32'h0);
      compare("trap_consumed.mis", 32'(misaligned_out), 32'd0);
      applyStimulus(0, 1, 32'h80, 0, 1);
      checkOutput("trap_exit", 0, 32'h0, NOP, 1, 32'h80);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("trap_resume", 1, 32'h80, 32'h25, 1, 32'h84);
      compare("trap_resume.mis", 32'(misaligned_out), 32'd0);
`endif

      // Random run scored against the expected instruction stream.
      applyStimulus(1, 0, 0, 0, 1);
      exp_pc       = RV;
      prev_pending = 1'b0;
      prev_addr    = 32'h0;
      consumed     = 0;
      for (int c = 0; c < 600; c++) begin
         r_br  = ($urandom_range(15) == 0);
         r_bpc = $urandom & 32'h0000FFFC;
         r_st  = ($urandom_range(3) == 0);
         r_rdy = ($urandom_range(2) != 0);
         reset           = 1'b0;
         branch_taken_in = r_br;
         branch_pc_in    = r_bpc;
         stall_in        = r_st;
         instr_ready_in  = r_rdy;
         if (prev_pending) begin
            compare("bus.read_held", 32'(instr_read_out), 32'd1);
            compare("bus.addr_held", instr_address_out, prev_addr);
         end
         if (!valid_out) begin
            compare("bubble.pc", pc_out, 32'h0);
            compare("bubble.instr", instr_out, NOP);
         end
`ifdef RV32_FETCH_MISALIGNED_EN
         compare("rand.mis", 32'(misaligned_out), 32'd0);
`endif
         if (r_br) begin
            exp_pc = r_bpc;
         end else if (valid_out && !r_st) begin
            compare("stream.pc", pc_out, exp_pc);
            compare("stream.instr", instr_out, exp_pc ^ 32'h000000A5);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         prev_pending = instr_read_out && !r_rdy;
         prev_addr    = instr_address_out;
         @(posedge clk);
         #1;
      end
      compare("throughput", 32'(consumed > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rv32_fetch.md
Name: rv32_fetch

Overview:
- Instruction fetch stage and IF/ID pipeline register of the RV32 core.
- Owns the architectural fetch PC and drives the instruction memory read port.
- Consumes the redirect produced by the branch target mux and branch-taken logic in execute.
- Feeds decode with valid/pc/instr, with stall and redirect handling and a one-entry capture buffer.

Parameters:
- RESET_VECTOR, 32'h00000000, fetch PC loaded on reset.
- NOP_INSN, 32'h00000013, value driven on instr_out when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high
- stall_in  input  1  decode cannot accept a new instruction this cycle
- branch_taken_in  input  1  redirect request from execute
- branch_pc_in  input  32  redirect target, bit0 already cleared
- instr_read_out  output  1  memory read request
- instr_address_out  output  32  read address (current fetch PC)
- instr_read_value_in  input  32  read data, valid when instr_ready_in=1
- instr_ready_in  input  1  read completes this cycle
- valid_out  output  1  IF/ID entry valid
- pc_out  output  32  PC of IF/ID instruction
- instr_out  output  32  IF/ID instruction
- misaligned_out  output  1  only with RV32_FETCH_MISALIGNED_EN

Behaviour:
- Reset values:
  - pc = RESET_VECTOR; state = FETCH; buffer empty.
  - valid_out = 0; pc_out = 0; instr_out = NOP_INSN; misaligned_out = 0.
  - instr_read_out = 0 while reset is high.
- Bus rules:
  - Handshake = instr_read_out & instr_ready_in; data is sampled the same cycle.
  - Once a request is raised, instr_address_out must stay constant until the handshake completes.
- Priority: branch_taken_in > stall_in > memory.
- A taken branch always clears valid_out on the next edge (flushes IF/ID); pc_out/instr_out then read 0/NOP_INSN.
- States:
  - FETCH: instr_read_out = 1.
    - Handshake, no branch, !stall: IF/ID <= {1, pc, read_value}; pc += 4 (mod 2^32, wraps FFFFFFFC -> 0).
    - Handshake, no branch, stall: buffer <= {pc, read_value}; pc += 4; go to HOLD; IF/ID held.
    - Handshake + branch: drop data; pc <= branch_pc_in; stay in FETCH.
    - No handshake + branch: pending <= branch_pc_in; go to DRAIN (address held).
    - No handshake, no branch: if !stall, valid_out <= 0 (bubble); if stall, IF/ID held.
  - DRAIN: instr_read_out = 1 at the old address; valid_out = 0.
    - A branch arriving in DRAIN overwrites pending.
    - On handshake: discard data; pc <= (branch this cycle ? branch_pc_in : pending); go to FETCH.
  - HOLD: instr_read_out = 0.
    - Branch: discard buffer; pc <= branch_pc_in; go to FETCH.
    - Else if !stall: IF/ID <= {1, buffer}; go to FETCH.
    - Else hold.
- Latency:
  - Zero-wait memory: one instruction per cycle; first valid_out 1 cycle after reset deasserts.
  - Redirect: first target instruction valid 2 cycles after branch_taken_in.
- Reset mid-operation (DRAIN/HOLD): all state returns to reset values; the outstanding request is abandoned.

Optional Feature:
- Macro: RV32_FETCH_MISALIGNED_EN.
- Enabled:
  - Port misaligned_out exists.
  - A taken branch with branch_pc_in[1]=1 does not fetch. Next edge: IF/ID <= {valid=1, pc_out=branch_pc_in, instr_out=NOP_INSN, misaligned_out=1}; state TRAP.
  - TRAP: instr_read_out = 0. IF/ID holds while stall_in; clears to invalid once consumed. Exits only on a later branch_taken_in (trap vector) or reset.
  - In DRAIN, a misaligned target enters TRAP after the handshake.
  - misaligned_out = 0 for every other entry.
- Disabled: no port, no TRAP state; target bit1 is passed to instr_address_out unchanged.

Test Plan:
- Reset with RESET_VECTOR=0x100, memory always ready returning addr^0xA5 -> valid_out=1 with pc_out 0x100, 0x104, 0x108 on consecutive cycles, instr_out matching.
- Stall 3 cycles while ready=1 at pc 0x104 -> one read of 0x104 buffered, instr_read_out=0 in HOLD, IF/ID shows 0x100 until release, then 0x104, 0x108 with no loss or duplicate.
- Ready low 4 cycles, branch to 0x2000 in wait cycle 2 -> address stays 0x108 until ready, that data discarded, next address 0x2000, valid_out=0 throughout, first valid pc_out=0x2000.
- Branch to 0x40 and stall asserted same cycle while in HOLD -> buffer dropped, valid_out=0 next cycle, fetch resumes at 0x40.
- PC at 0xFFFFFFFC, ready -> next address 0x00000000; reset asserted in DRAIN -> next cycle instr_read_out=0, valid_out=0, then fetch at RESET_VECTOR.
- With RV32_FETCH_MISALIGNED_EN, branch to 0x302 -> valid_out=1, misaligned_out=1, pc_out=0x302, instr_out=0x00000013, no further reads until branch to 0x80 restarts fetch there.
